// File: rtl/bj_resolve_unit.sv
// ---------------------------------------------------------------------------
// bj_resolve_unit : branch/jump resolution stage with mispredict flush FSM
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bj_resolve_unit #(
   parameter int DATA_WIDTH   = 32,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  STALL,
   input  logic                  VALID_IN,
   input  logic [2:0]            BRANCH_JUMP,
   input  logic                  JALR,
   input  logic                  PREDICTED_TAKEN,
   input  logic [DATA_WIDTH-1:0] DATA1,
   input  logic [DATA_WIDTH-1:0] DATA2,
   input  logic [DATA_WIDTH-1:0] PC,
   input  logic [DATA_WIDTH-1:0] IMM,
   output logic                  VALID_OUT,
   output logic                  PC_SEL,
   output logic [DATA_WIDTH-1:0] TARGET,
   output logic                  MISPREDICT,
   output logic                  FLUSH,
   output logic                  BUSY,
   output logic [CNT_WIDTH-1:0]  TAKEN_CNT,
   output logic [CNT_WIDTH-1:0]  MISPRED_CNT
);

   localparam logic [2:0] BJ_NO   = 3'd0;
   localparam logic [2:0] BJ_J    = 3'd1;
   localparam logic [2:0] BJ_BEQ  = 3'd2;
   localparam logic [2:0] BJ_BNE  = 3'd3;
   localparam logic [2:0] BJ_BLT  = 3'd4;
   localparam logic [2:0] BJ_BGE  = 3'd5;
   localparam logic [2:0] BJ_BLTU = 3'd6;
   localparam logic [2:0] BJ_BGEU = 3'd7;

   localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);
   localparam logic [DATA_WIDTH-1:0] LSB_CLEAR = ~{{(DATA_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic {S_IDLE, S_FLUSH} state_t;

   state_t                state_q;
   logic [3:0]            fcnt_q;
   logic                  valid_q;
   logic                  pc_sel_q;
   logic [DATA_WIDTH-1:0] target_q;
   logic                  mispredict_q;
   logic [CNT_WIDTH-1:0]  taken_cnt_q;
   logic [CNT_WIDTH-1:0]  mispred_cnt_q;

   logic                  taken_d;
   logic [DATA_WIDTH-1:0] target_d;
   logic [DATA_WIDTH-1:0] jalr_sum_d;

   always_comb begin
      taken_d = 1'b0;
      case (BRANCH_JUMP)
         BJ_NO:   taken_d = 1'b0;
         BJ_J:    taken_d = 1'b1;
         BJ_BEQ:  taken_d = (DATA1 == DATA2);
         BJ_BNE:  taken_d = (DATA1 != DATA2);
         BJ_BLT:  taken_d = ($signed(DATA1) <  $signed(DATA2));
         BJ_BGE:  taken_d = ($signed(DATA1) >= $signed(DATA2));
         BJ_BLTU: taken_d = (DATA1 <  DATA2);
         BJ_BGEU: taken_d = (DATA1 >= DATA2);
         default: taken_d = 1'b0;
      endcase
   end

   always_comb begin
      jalr_sum_d = DATA1 + IMM;
      target_d   = PC + DATA_WIDTH'(4);
      if (BRANCH_JUMP == BJ_J && JALR) begin
         target_d = jalr_sum_d & LSB_CLEAR;
      end else if (taken_d) begin
         target_d = PC + IMM;
      end
   end

   // Mispredict is decided at capture so the pulse lines up with the new result.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q       <= S_IDLE;
         fcnt_q        <= 4'd0;
         valid_q       <= 1'b0;
         pc_sel_q      <= 1'b0;
         target_q      <= '0;
         mispredict_q  <= 1'b0;
         taken_cnt_q   <= '0;
         mispred_cnt_q <= '0;
      end else begin
         mispredict_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (mispredict_q) begin
                  state_q <= S_FLUSH;
                  fcnt_q  <= FLUSH_LOAD;
                  valid_q <= 1'b0;
               end else if (!STALL) begin
                  valid_q <= VALID_IN;
                  if (VALID_IN) begin
                     pc_sel_q <= taken_d;
                     target_q <= target_d;
                     if (taken_d != PREDICTED_TAKEN) begin
                        mispredict_q <= 1'b1;
                        if (mispred_cnt_q != '1) begin
                           mispred_cnt_q <= mispred_cnt_q + 1'b1;
                        end
                     end
                     if (taken_d && taken_cnt_q != '1) begin
                        taken_cnt_q <= taken_cnt_q + 1'b1;
                     end
                  end
               end
            end
            S_FLUSH: begin
               if (fcnt_q <= 4'd1) begin
                  state_q <= S_IDLE;
                  fcnt_q  <= 4'd0;
               end else begin
                  fcnt_q <= fcnt_q - 4'd1;
               end
            end
            default: begin
               state_q <= S_IDLE;
               fcnt_q  <= 4'd0;
            end
         endcase
      end
   end

   assign VALID_OUT   = valid_q;
   assign PC_SEL      = pc_sel_q;
   assign TARGET      = target_q;
   assign MISPREDICT  = mispredict_q;
   assign FLUSH       = (state_q == S_FLUSH);
   assign BUSY        = (state_q == S_FLUSH);
   assign TAKEN_CNT   = taken_cnt_q;
   assign MISPRED_CNT = mispred_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_bj_resolve_unit.sv
// ---------------------------------------------------------------------------
// tb_bj_resolve_unit : vector table + scoreboard bench for bj_resolve_unit
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_bj_resolve_unit;

   logic        CLK = 1'b0;
   logic        RESET, RESET2, STALL, VALID_IN, JALR, PREDICTED_TAKEN;
   logic [2:0]  BRANCH_JUMP;
   logic [31:0] DATA1, DATA2, PC, IMM;

   logic        VALID_OUT, PC_SEL, MISPREDICT, FLUSH, BUSY;
   logic [31:0] TARGET;
   logic [15:0] TAKEN_CNT, MISPRED_CNT;

   logic        VALID_OUT2, PC_SEL2, MISPREDICT2, FLUSH2, BUSY2;
   logic [31:0] TARGET2;
   logic [1:0]  TAKEN_CNT2, MISPRED_CNT2;

   always #5 CLK = ~CLK;

   bj_resolve_unit #(.DATA_WIDTH(32), .FLUSH_CYCLES(2), .CNT_WIDTH(16)) dut (
      .CLK(CLK), .RESET(RESET), .STALL(STALL), .VALID_IN(VALID_IN),
      .BRANCH_JUMP(BRANCH_JUMP), .JALR(JALR), .PREDICTED_TAKEN(PREDICTED_TAKEN),
      .DATA1(DATA1), .DATA2(DATA2), .PC(PC), .IMM(IMM),
      .VALID_OUT(VALID_OUT), .PC_SEL(PC_SEL), .TARGET(TARGET),
      .MISPREDICT(MISPREDICT), .FLUSH(FLUSH), .BUSY(BUSY),
      .TAKEN_CNT(TAKEN_CNT), .MISPRED_CNT(MISPRED_CNT)
   );

   bj_resolve_unit #(.DATA_WIDTH(32), .FLUSH_CYCLES(2), .CNT_WIDTH(2)) dut2 (
      .CLK(CLK), .RESET(RESET2), .STALL(STALL), .VALID_IN(VALID_IN),
      .BRANCH_JUMP(BRANCH_JUMP), .JALR(JALR), .PREDICTED_TAKEN(PREDICTED_TAKEN),
      .DATA1(DATA1), .DATA2(DATA2), .PC(PC), .IMM(IMM),
      .VALID_OUT(VALID_OUT2), .PC_SEL(PC_SEL2), .TARGET(TARGET2),
      .MISPREDICT(MISPREDICT2), .FLUSH(FLUSH2), .BUSY(BUSY2),
      .TAKEN_CNT(TAKEN_CNT2), .MISPRED_CNT(MISPRED_CNT2)
   );

   typedef struct {
      logic [2:0]  bj;
      logic        jalr;
      logic        pred;
      logic [31:0] d1, d2, pc, imm;
      logic        sel;
      logic [31:0] tgt;
      logic        mis;
   } vec_t;

   typedef struct {
      logic        sel;
      logic [31:0] tgt;
      logic        mis;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   exp_tc   = 0;
   int   exp_mc   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      exp_t e;
      BRANCH_JUMP     = v.bj;
      JALR            = v.jalr;
      PREDICTED_TAKEN = v.pred;
      DATA1 = v.d1; DATA2 = v.d2; PC = v.pc; IMM = v.imm;
      VALID_IN = 1'b1;
      e.sel = v.sel; e.tgt = v.tgt; e.mis = v.mis;
      sb.push_back(e);
   endtask

   task automatic check_out(input string nm);
      exp_t e;
      chk({nm, ".valid"}, 64'(VALID_OUT), 64'd1);
      if (sb.size() == 0) begin
         chk({nm, ".sb_empty"}, 64'd0, 64'd1);
      end else begin
         e = sb.pop_front();
         if (e.sel && exp_tc < 65535) exp_tc++;
         if (e.mis && exp_mc < 65535) exp_mc++;
         chk({nm, ".pc_sel"}, 64'(PC_SEL), 64'(e.sel));
         chk({nm, ".target"}, 64'(TARGET), 64'(e.tgt));
         chk({nm, ".mispredict"}, 64'(MISPREDICT), 64'(e.mis));
         chk({nm, ".taken_cnt"}, 64'(TAKEN_CNT), 64'(exp_tc));
         chk({nm, ".mispred_cnt"}, 64'(MISPRED_CNT), 64'(exp_mc));
      end
   endtask

   task automatic check_flush(input string nm);
      for (int i = 0; i < 2; i++) begin
         @(negedge CLK);
         chk({nm, ".flush"}, 64'(FLUSH), 64'd1);
         chk({nm, ".busy"}, 64'(BUSY), 64'd1);
         chk({nm, ".valid_in_flush"}, 64'(VALID_OUT), 64'd0);
         chk({nm, ".mis_in_flush"}, 64'(MISPREDICT), 64'd0);
      end
      @(negedge CLK);
      chk({nm, ".flush_end"}, 64'(FLUSH), 64'd0);
      chk({nm, ".busy_end"}, 64'(BUSY), 64'd0);
   endtask

   task automatic run_vec(input vec_t v, input string nm);
      drive(v);
      @(negedge CLK);
      VALID_IN = 1'b0;
      check_out(nm);
      if (v.mis) check_flush(nm);
   endtask

   vec_t tbl[15];
   vec_t v_j_jalr, v_blt_mis, v_bltu_mis, v_beq_take, v_bne, v_j;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      //            bj    jalr pred d1            d2     pc            imm           sel tgt           mis
      tbl[0]  = '{3'd2, 1'b0, 1'b1, 32'd10,       32'd10, 32'h100,      32'h20,       1'b1, 32'h120,      1'b0};
      tbl[1]  = '{3'd6, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd1,  32'h200,      32'h40,       1'b0, 32'h204,      1'b1};
      tbl[2]  = '{3'd4, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1,  32'h300,      32'h40,       1'b1, 32'h340,      1'b1};
      tbl[3]  = '{3'd3, 1'b0, 1'b1, 32'd5,        32'd6,  32'h10,       32'hFFFFFFF0, 1'b1, 32'h0,        1'b0};
      tbl[4]  = '{3'd5, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1,  32'h400,      32'h8,        1'b0, 32'h404,      1'b0};
      tbl[5]  = '{3'd7, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd1,  32'h400,      32'h8,        1'b1, 32'h408,      1'b0};
      tbl[6]  = '{3'd1, 1'b0, 1'b1, 32'h1001,     32'd0,  32'h1000,     32'h100,      1'b1, 32'h1100,     1'b0};
      tbl[7]  = '{3'd1, 1'b1, 1'b1, 32'h1001,     32'd0,  32'h500,      32'h10,       1'b1, 32'h1010,     1'b0};
      tbl[8]  = '{3'd0, 1'b0, 1'b0, 32'd0,        32'd0,  32'h50,       32'h20,       1'b0, 32'h54,       1'b0};
      tbl[9]  = '{3'd2, 1'b1, 1'b0, 32'd3,        32'd4,  32'h60,       32'h8,        1'b0, 32'h64,       1'b0};
      tbl[10] = '{3'd2, 1'b0, 1'b1, 32'd7,        32'd7,  32'hFFFFFFFC, 32'h8,        1'b1, 32'h4,        1'b0};
      tbl[11] = '{3'd0, 1'b1, 1'b1, 32'd1,        32'd2,  32'hFFFFFFFC, 32'h8,        1'b0, 32'h0,        1'b1};
      tbl[12] = '{3'd4, 1'b0, 1'b0, 32'd5,        32'd5,  32'h70,       32'h20,       1'b0, 32'h74,       1'b0};
      tbl[13] = '{3'd1, 1'b1, 1'b0, 32'hFFFFFFF0, 32'd0,  32'h700,      32'h13,       1'b1, 32'h2,        1'b1};
      tbl[14] = '{3'd2, 1'b1, 1'b1, 32'd9,        32'd9,  32'h600,      32'h11,       1'b1, 32'h611,      1'b0};

      v_j_jalr   = tbl[7];
      v_blt_mis  = tbl[2];
      v_bltu_mis = tbl[1];
      v_beq_take = tbl[0];
      v_bne      = '{3'd3, 1'b0, 1'b1, 32'd5, 32'd6, 32'h80, 32'h10, 1'b1, 32'h90, 1'b0};
      v_j        = '{3'd1, 1'b0, 1'b1, 32'd0, 32'd0, 32'h900, 32'h4, 1'b1, 32'h904, 1'b0};

      RESET = 1'b0; RESET2 = 1'b0; STALL = 1'b0; VALID_IN = 1'b0;
      BRANCH_JUMP = 3'd0; JALR = 1'b0; PREDICTED_TAKEN = 1'b0;
      DATA1 = '0; DATA2 = '0; PC = '0; IMM = '0;

      repeat (2) @(negedge CLK);
      chk("reset.valid", 64'(VALID_OUT), 64'd0);
      chk("reset.pc_sel", 64'(PC_SEL), 64'd0);
      chk("reset.target", 64'(TARGET), 64'd0);
      chk("reset.flush_busy", 64'({FLUSH, BUSY, MISPREDICT}), 64'd0);
      chk("reset.counters", 64'({TAKEN_CNT, MISPRED_CNT}), 64'd0);

      RESET = 1'b1;
      for (int i = 0; i < 15; i++) begin
         run_vec(tbl[i], $sformatf("vec%0d", i));
      end
      @(negedge CLK);
      chk("idle.valid_clear", 64'(VALID_OUT), 64'd0);

      // Stall holds the result and blocks a would-be mispredict capture
      drive(v_j_jalr);
      @(negedge CLK);
      check_out("stall.cap");
      STALL = 1'b1;
      drive(v_blt_mis);
      void'(sb.pop_back());
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         chk("stall.valid", 64'(VALID_OUT), 64'd1);
         chk("stall.pc_sel", 64'(PC_SEL), 64'd1);
         chk("stall.target", 64'(TARGET), 64'h1010);
         chk("stall.mis", 64'(MISPREDICT), 64'd0);
         chk("stall.taken_cnt", 64'(TAKEN_CNT), 64'(exp_tc));
      end
      STALL = 1'b0; VALID_IN = 1'b0;
      @(negedge CLK);
      chk("stall.release_valid", 64'(VALID_OUT), 64'd0);

      // Mispredict followed by stall: single pulse, flush length unchanged
      drive(v_bltu_mis);
      @(negedge CLK);
      VALID_IN = 1'b0;
      check_out("mis_stall");
      STALL = 1'b1;
      check_flush("mis_stall");
      chk("mis_stall.no_repeat", 64'(MISPREDICT), 64'd0);
      chk("mis_stall.mis_cnt", 64'(MISPRED_CNT), 64'(exp_mc));
      STALL = 1'b0;

      // New VALID_IN coinciding with mispredict and during flush is dropped
      drive(v_blt_mis);
      @(negedge CLK);
      check_out("coincide");
      drive(v_beq_take);
      void'(sb.pop_back());
      check_flush("coincide");
      VALID_IN = 1'b0;
      chk("coincide.valid_after", 64'(VALID_OUT), 64'd0);
      @(negedge CLK);
      chk("coincide.dropped", 64'(VALID_OUT), 64'd0);
      chk("coincide.taken_cnt", 64'(TAKEN_CNT), 64'(exp_tc));

      // Asynchronous reset inside the first flush cycle
      drive(v_blt_mis);
      @(negedge CLK);
      VALID_IN = 1'b0;
      check_out("rst_flush");
      @(posedge CLK);
      #1;
      chk("rst_flush.in_flush", 64'(FLUSH), 64'd1);
      #1;
      RESET = 1'b0;
      #1;
      exp_tc = 0; exp_mc = 0;
      chk("rst_flush.valid", 64'(VALID_OUT), 64'd0);
      chk("rst_flush.pc_sel_target", 64'({PC_SEL, TARGET}), 64'd0);
      chk("rst_flush.ctrl", 64'({MISPREDICT, FLUSH, BUSY}), 64'd0);
      chk("rst_flush.counters", 64'({TAKEN_CNT, MISPRED_CNT}), 64'd0);
      @(negedge CLK);
      RESET = 1'b1;
      run_vec(v_bne, "post_rst_bne");

      // Narrow counter saturation on second instance
      RESET2 = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         v_j.pc = 32'h900 + 32'(k * 16);
         v_j.tgt = v_j.pc + 32'h4;
         run_vec(v_j, $sformatf("sat%0d", k));
         chk($sformatf("sat%0d.cnt2", k), 64'(TAKEN_CNT2), 64'((k < 3) ? k : 3));
      end

      @(negedge CLK);
      chk("sb.drained", 64'(sb.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/bj_resolve_unit.md
BJ_RESOLVE_UNIT -- requirements
Module: bj_resolve_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: operand, PC, immediate and target width.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2, legal range 1..15: length of the flush pulse after a mispredict.
REQ-003 SHALL have parameter CNT_WIDTH, default 16: width of the statistics counters.
REQ-004 SHALL have port CLK, input, 1: the single clock; all state updates on the rising edge.
REQ-005 SHALL have port RESET, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port STALL, input, 1: pipeline hold, which freezes the stage register.
REQ-007 SHALL have port VALID_IN, input, 1: the presented operation is real.
REQ-008 SHALL have port BRANCH_JUMP, input, 3: codebase encodings NO, J, BEQ, BNE, BLT, BGE, BLTU, BGEU.
REQ-009 SHALL have port JALR, input, 1: with J, selects a register-relative target.
REQ-010 SHALL have port PREDICTED_TAKEN, input, 1: the fetch-stage prediction for this operation.
REQ-011 SHALL have ports DATA1 and DATA2, input, DATA_WIDTH: compare operands; DATA1 is also the JALR base.
REQ-012 SHALL have ports PC and IMM, input, DATA_WIDTH: instruction address and sign-extended offset.
REQ-013 SHALL have port VALID_OUT, output, 1: the registered result is valid.
REQ-014 SHALL have port PC_SEL, output, 1: resolved taken.
REQ-015 SHALL have port TARGET, output, DATA_WIDTH: the redirect address.
REQ-016 SHALL have port MISPREDICT, output, 1: a one-cycle pulse when the resolution differs from the prediction.
REQ-017 SHALL have port FLUSH, output, 1: kill the younger pipeline stages.
REQ-018 SHALL have port BUSY, output, 1: FSM is in the FLUSH state.
REQ-019 SHALL have ports TAKEN_CNT and MISPRED_CNT, output, CNT_WIDTH: saturating statistics counters.

Function
REQ-020 SHALL resolve the condition combinationally from the inputs:
- NO: not taken.
- J: taken.
- BEQ / BNE: equal / not equal.
- BLT / BGE: signed less-than / signed greater-or-equal.
- BLTU / BGEU: unsigned less-than / unsigned greater-or-equal.
- Undefined codes: not taken.
REQ-021 SHALL compute the target at DATA_WIDTH with wrap-around and no carry-out:
- JALR=1 with J: (DATA1+IMM) with bit 0 cleared.
- Otherwise taken: PC+IMM.
- Not taken: PC+4.
REQ-022 SHALL ignore JALR unless BRANCH_JUMP is J.
REQ-023 SHALL capture the operation into the stage register on the rising edge when VALID_IN=1, STALL=0 and the FSM is IDLE.
- Latency is exactly 1 cycle.
- VALID_OUT, PC_SEL and TARGET come from that register.
REQ-024 SHALL, when VALID_IN=0 under the same conditions, clear VALID_OUT on the next edge.
REQ-025 SHALL, while STALL=1, hold VALID_OUT, PC_SEL and TARGET unchanged and suppress repeat MISPREDICT pulses and counter updates.
REQ-026 SHALL assert MISPREDICT for exactly one cycle, in the cycle a valid result first appears with PC_SEL != the registered PREDICTED_TAKEN.
REQ-027 SHALL implement a two-state FSM:
- IDLE to FLUSH on MISPREDICT, loading the down-counter with FLUSH_CYCLES.
- FLUSH decrements the counter each cycle, regardless of STALL.
- FLUSH to IDLE when the counter reaches 1.
REQ-028 SHALL assert FLUSH and BUSY in every FLUSH-state cycle, for exactly FLUSH_CYCLES consecutive cycles starting the cycle after MISPREDICT.
REQ-029 SHALL drop VALID_IN during FLUSH, capturing nothing.
REQ-030 SHALL clear VALID_OUT on the first FLUSH cycle.
REQ-031 SHALL increment TAKEN_CNT once per newly valid taken result and MISPRED_CNT once per MISPREDICT pulse.
REQ-032 SHALL saturate both counters at all-ones, with no wrap.
REQ-033 SHALL, when MISPREDICT and a new VALID_IN coincide, take the flush: the new input is not captured.

Reset
REQ-034 SHALL, with RESET=0 at any time including mid-flush, immediately drive to 0: VALID_OUT, PC_SEL, TARGET, MISPREDICT, FLUSH, BUSY, TAKEN_CNT, MISPRED_CNT and the flush counter.
REQ-035 SHALL force the FSM to IDLE while RESET=0.
REQ-036 SHALL accept the first capture on the first rising edge with RESET=1.

Verification
REQ-037 SHALL cover BEQ with DATA1=DATA2=10, PC=0x100, IMM=0x20, PREDICTED_TAKEN=1 -> next cycle PC_SEL=1, TARGET=0x120, MISPREDICT=0, TAKEN_CNT=1.
REQ-038 SHALL cover BLT with DATA1=0xFFFFFFFF, DATA2=1, PREDICTED_TAKEN=0 -> PC_SEL=1, MISPREDICT pulse, then FLUSH=1 for exactly 2 cycles, and a VALID_IN during the flush is dropped.
REQ-039 SHALL cover BLTU with the same operands as REQ-038, PC=0x200 -> PC_SEL=0, TARGET=0x204; with PREDICTED_TAKEN=1 -> MISPREDICT=1, MISPRED_CNT=1.
REQ-040 SHALL cover J with JALR=1, DATA1=0x1001, IMM=0x10 -> TARGET=0x1010; then STALL=1 for 3 cycles -> outputs held, TAKEN_CNT unchanged.
REQ-041 SHALL cover RESET=0 asserted in the 1st FLUSH cycle -> all outputs 0 at once; after release, a BNE with 5,6 resolves PC_SEL=1 one cycle after capture.
REQ-042 SHALL cover CNT_WIDTH=2 with 5 taken J operations -> TAKEN_CNT saturates at 3.
